// File: rtl/wb_stage_pipe.sv
// Write-back stage: picks ALU/load/PC+4/IMM, formats loads,
// waits on memory, drives the register file and a retire count.
// Ports: in_valid_i/in_ready_o handshake from MEM, flush_i,
//   rd_i/rd_we_i/wb_sel_i/funct3_i/addr_lo_i/alu_i/pc_4_i/imm_i,
//   mem_rsp_valid_i/mem_i load response, rf_we_o/rf_waddr_o/
//   rf_wdata_o register-file write, busy_o, retired_o.
module wb_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        flush_i,
  input  logic [RF_AW-1:0]            rd_i,
  input  logic                        rd_we_i,
  input  logic [1:0]                  wb_sel_i,
  input  logic [2:0]                  funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]   addr_lo_i,
  input  logic [XLEN-1:0]             alu_i,
  input  logic [XLEN-1:0]             pc_4_i,
  input  logic [XLEN-1:0]             imm_i,
  input  logic                        mem_rsp_valid_i,
  input  logic [XLEN-1:0]             mem_i,
  output logic                        rf_we_o,
  output logic [RF_AW-1:0]            rf_waddr_o,
  output logic [XLEN-1:0]             rf_wdata_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            retired_o
);

  localparam int AW = $clog2(XLEN/8);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic             xfer;
  logic             is_load;
  logic             new_wr;
  logic             load_wr;
  logic [XLEN-1:0]  sel_val;

  logic [RF_AW-1:0] rd_q;
  logic             rd_we_q;
  logic [2:0]       f3_q;
  logic [AW-1:0]    lo_q;

  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] d,
    input logic [2:0]      f3,
    input logic [AW-1:0]   lo
  );
    logic [AW+2:0]   bsh;
    logic [AW+2:0]   hsh;
    logic [AW+2:0]   wsh;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] h;
    logic [XLEN-1:0] w;
    logic [XLEN-1:0] r;
    bsh = {lo, 3'b000};
    // half/word lanes ignore the low offset bits
    hsh = (bsh >> 4) << 4;
    wsh = (bsh >> 5) << 5;
    b = d >> bsh;
    h = d >> hsh;
    w = d >> wsh;
    r = d;
    case (f3)
      3'b000: r = XLEN'($signed(b[7:0]));
      3'b100: r = XLEN'(b[7:0]);
      3'b001: r = XLEN'($signed(h[15:0]));
      3'b101: r = XLEN'(h[15:0]);
      3'b010: r = XLEN'($signed(w[31:0]));
      3'b110: r = (XLEN == 64) ? XLEN'(w[31:0]) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  assign in_ready_o = rst & !flush_i &
                      (state_q == IDLE || state_q == WRITE);
  assign xfer    = in_valid_i & in_ready_o;
  assign is_load = (wb_sel_i == 2'b01);
  assign busy_o  = (state_q != IDLE);
  assign new_wr  = xfer & !is_load;
  assign load_wr = (state_q == WAIT_MEM) & !flush_i &
                   mem_rsp_valid_i;

  always_comb begin
    sel_val = alu_i;
    case (wb_sel_i)
      2'b10:   sel_val = pc_4_i;
      2'b11:   sel_val = imm_i;
      default: sel_val = alu_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WRITE: begin
        if (xfer)
          state_d = is_load ? WAIT_MEM : WRITE;
        else
          state_d = IDLE;
      end
      WAIT_MEM: begin
        if (flush_i)
          state_d = mem_rsp_valid_i ? IDLE : DRAIN;
        else if (mem_rsp_valid_i)
          state_d = WRITE;
      end
      DRAIN: begin
        if (mem_rsp_valid_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
    end else if (xfer) begin
      rd_q    <= rd_i;
      rd_we_q <= rd_we_i;
      f3_q    <= funct3_i;
      lo_q    <= addr_lo_i;
    end
  end

  // outputs load on entry to WRITE and hold until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      retired_o  <= '0;
    end else if (new_wr) begin
      rf_we_o    <= rd_we_i & (rd_i != '0);
      rf_waddr_o <= rd_i;
      rf_wdata_o <= sel_val;
      retired_o  <= retired_o + CNT_W'(1);
    end else if (load_wr) begin
      rf_we_o    <= rd_we_q & (rd_q != '0);
      rf_waddr_o <= rd_q;
      rf_wdata_o <= fmt_load(mem_i, f3_q, lo_q);
      retired_o  <= retired_o + CNT_W'(1);
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: ALU, loads, x0, streaming,
// flush/drain, async reset mid-load and counter wrap.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [4:0]  rd;
  logic        rd_we;
  logic [1:0]  wb_sel;
  logic [2:0]  f3;
  logic [1:0]  addr_lo;
  logic [31:0] alu;
  logic [31:0] pc4;
  logic [31:0] imm;
  logic        rsp_valid;
  logic [31:0] mem;

  logic        in_ready;
  logic        rf_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] retired;

  logic        w_in_ready;
  logic        w_rf_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_busy;
  logic [3:0]  retired4;

  int          nchk = 0;
  int          nfail = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(32), .RF_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .rd_i(rd), .rd_we_i(rd_we),
    .wb_sel_i(wb_sel), .funct3_i(f3), .addr_lo_i(addr_lo),
    .alu_i(alu), .pc_4_i(pc4), .imm_i(imm),
    .mem_rsp_valid_i(rsp_valid), .mem_i(mem),
    .rf_we_o(rf_we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .busy_o(busy), .retired_o(retired)
  );

  wb_stage_pipe #(.XLEN(32), .RF_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(w_in_ready),
    .flush_i(flush), .rd_i(rd), .rd_we_i(rd_we),
    .wb_sel_i(wb_sel), .funct3_i(f3), .addr_lo_i(addr_lo),
    .alu_i(alu), .pc_4_i(pc4), .imm_i(imm),
    .mem_rsp_valid_i(rsp_valid), .mem_i(mem),
    .rf_we_o(w_rf_we), .rf_waddr_o(w_waddr), .rf_wdata_o(w_wdata),
    .busy_o(w_busy), .retired_o(retired4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid  = 1'b0;
    flush     = 1'b0;
    rsp_valid = 1'b0;
  endtask

  task automatic set_op(input logic [4:0] r, input logic we,
                        input logic [1:0] s, input logic [31:0] v,
                        input logic [2:0] f, input logic [1:0] lo);
    in_valid = 1'b1;
    rd       = r;
    rd_we    = we;
    wb_sel   = s;
    f3       = f;
    addr_lo  = lo;
    alu      = 32'hDEAD0001;
    pc4      = 32'hDEAD0002;
    imm      = 32'hDEAD0003;
    case (s)
      2'b00:   alu = v;
      2'b10:   pc4 = v;
      2'b11:   imm = v;
      default: ;
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle();
    rd = '0; rd_we = 1'b0; wb_sel = '0; f3 = '0; addr_lo = '0;
    alu = '0; pc4 = '0; imm = '0; mem = '0;
    step(); step(); step();
    nchk++;
    if ({rf_we, waddr, wdata, busy} !== '0) begin
      nfail++;
      $display("FAIL reset_outs got we=%0b a=%0h d=%0h b=%0b exp 0",
               rf_we, waddr, wdata, busy);
    end
    nchk++;
    if (retired !== 32'd0 || retired4 !== 4'd0) begin
      nfail++;
      $display("FAIL reset_ret got %0h/%0h exp 0", retired, retired4);
    end
    rst = 1'b1;
    exp_ret = 0;
    step();
  endtask

  task automatic test_alu;
    set_op(5'd5, 1'b1, 2'b00, 32'h1234, 3'b000, 2'd0);
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL t1_ready got %0b exp 1", in_ready);
    end
    step();
    exp_ret++;
    nchk++;
    if (rf_we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234) begin
      nfail++;
      $display("FAIL t1_write got we=%0b a=%0h d=%0h exp 1/5/1234",
               rf_we, waddr, wdata);
    end
    nchk++;
    if (retired !== exp_ret) begin
      nfail++;
      $display("FAIL t1_ret got %0d exp %0d", retired, exp_ret);
    end
    idle();
    step();
    nchk++;
    if (rf_we !== 1'b0 || waddr !== 5'd5 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL t1_after got we=%0b a=%0h b=%0b exp 0/5/0",
               rf_we, waddr, busy);
    end
  endtask

  task automatic test_load;
    logic [2:0]  fs [5];
    logic [1:0]  los [5];
    logic [31:0] ex [5];
    fs  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    los = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    ex  = '{32'hFFFFFF80, 32'h00000080, 32'h00000080,
            32'hFFFFFF00, 32'h0080FF00};
    for (int i = 0; i < 5; i++) begin
      set_op(5'd7, 1'b1, 2'b01, 32'h0, fs[i], los[i]);
      mem = 32'h0080FF00;
      step();
      idle();
      #1;
      nchk++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        nfail++;
        $display("FAIL t2_wait%0d got rdy=%0b busy=%0b exp 0/1",
                 i, in_ready, busy);
      end
      step();
      step();
      nchk++;
      if (rf_we !== 1'b0) begin
        nfail++;
        $display("FAIL t2_nowr%0d got %0b exp 0", i, rf_we);
      end
      rsp_valid = 1'b1;
      step();
      exp_ret++;
      nchk++;
      if (rf_we !== 1'b1 || waddr !== 5'd7 || wdata !== ex[i]) begin
        nfail++;
        $display("FAIL t2_load%0d got we=%0b a=%0h d=%0h exp 1/7/%0h",
                 i, rf_we, waddr, wdata, ex[i]);
      end
      nchk++;
      if (retired !== exp_ret) begin
        nfail++;
        $display("FAIL t2_ret%0d got %0d exp %0d", i, retired, exp_ret);
      end
      rsp_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_x0;
    set_op(5'd0, 1'b1, 2'b10, 32'h100, 3'b000, 2'd0);
    step();
    exp_ret++;
    nchk++;
    if (rf_we !== 1'b0 || wdata !== 32'h100) begin
      nfail++;
      $display("FAIL t3_x0 got we=%0b d=%0h exp 0/100", rf_we, wdata);
    end
    nchk++;
    if (retired !== exp_ret) begin
      nfail++;
      $display("FAIL t3_ret got %0d exp %0d", retired, exp_ret);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ss [4];
    logic [31:0] vs [4];
    ss = '{2'b00, 2'b10, 2'b11, 2'b00};
    vs = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      set_op(5'(i + 1), 1'b1, ss[i], vs[i], 3'b000, 2'd0);
      #1;
      nchk++;
      if (in_ready !== 1'b1) begin
        nfail++;
        $display("FAIL t4_ready%0d got %0b exp 1", i, in_ready);
      end
      step();
      nchk++;
      if (rf_we !== 1'b1 || waddr !== 5'(i + 1) || wdata !== vs[i]) begin
        nfail++;
        $display("FAIL t4_wr%0d got we=%0b a=%0h d=%0h exp 1/%0h/%0h",
                 i, rf_we, waddr, wdata, i + 1, vs[i]);
      end
    end
    exp_ret += 4;
    idle();
    nchk++;
    if (retired !== exp_ret) begin
      nfail++;
      $display("FAIL t4_ret got %0d exp %0d", retired, exp_ret);
    end
    step();
    nchk++;
    if (rf_we !== 1'b0 || wdata !== 32'h44) begin
      nfail++;
      $display("FAIL t4_end got we=%0b d=%0h exp 0/44", rf_we, wdata);
    end
  endtask

  task automatic test_flush;
    set_op(5'd9, 1'b1, 2'b01, 32'h0, 3'b010, 2'd0);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    nchk++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || rf_we !== 1'b0) begin
      nfail++;
      $display("FAIL t5_drain got b=%0b rdy=%0b we=%0b exp 1/0/0",
               busy, in_ready, rf_we);
    end
    step();
    rsp_valid = 1'b1;
    mem = 32'h12345678;
    step();
    rsp_valid = 1'b0;
    nchk++;
    if (busy !== 1'b0 || rf_we !== 1'b0 || retired !== exp_ret) begin
      nfail++;
      $display("FAIL t5_dropped got b=%0b we=%0b r=%0d exp 0/0/%0d",
               busy, rf_we, retired, exp_ret);
    end
    step();
    nchk++;
    if (rf_we !== 1'b0) begin
      nfail++;
      $display("FAIL t5_nowr got %0b exp 0", rf_we);
    end
    set_op(5'd9, 1'b1, 2'b01, 32'h0, 3'b010, 2'd0);
    step();
    idle();
    flush = 1'b1;
    rsp_valid = 1'b1;
    step();
    idle();
    nchk++;
    if (busy !== 1'b0 || rf_we !== 1'b0 || retired !== exp_ret) begin
      nfail++;
      $display("FAIL t5_same got b=%0b we=%0b r=%0d exp 0/0/%0d",
               busy, rf_we, retired, exp_ret);
    end
    step();
  endtask

  task automatic test_reset_mid_load;
    set_op(5'd3, 1'b1, 2'b01, 32'h0, 3'b010, 2'd0);
    step();
    idle();
    #2;
    rst = 1'b0;
    #1;
    nchk++;
    if ({rf_we, waddr, wdata, busy} !== '0 || retired !== 32'd0) begin
      nfail++;
      $display("FAIL t6_rst got we=%0b a=%0h d=%0h b=%0b r=%0d exp 0",
               rf_we, waddr, wdata, busy, retired);
    end
    step();
    rst = 1'b1;
    exp_ret = 0;
    rsp_valid = 1'b1;
    mem = 32'hCAFEF00D;
    step();
    rsp_valid = 1'b0;
    nchk++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || wdata !== 32'h0) begin
      nfail++;
      $display("FAIL t6_stray got we=%0b b=%0b d=%0h exp 0/0/0",
               rf_we, busy, wdata);
    end
    step();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 17; i++) begin
      set_op(5'(i + 1), 1'b1, 2'b00, 32'(i), 3'b000, 2'd0);
      step();
    end
    exp_ret += 17;
    idle();
    nchk++;
    if (retired !== exp_ret) begin
      nfail++;
      $display("FAIL t6_ret32 got %0d exp %0d", retired, exp_ret);
    end
    nchk++;
    if (retired4 !== 4'd1) begin
      nfail++;
      $display("FAIL t6_wrap got %0d exp 1", retired4);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0();
    test_back_to_back();
    test_flush();
    test_reset_mid_load();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
